// File: rtl/jtag_scan_pkg.sv
// Shared definitions for the JTAG scan master: command op codes, FSM state
// encoding and the default scan width of the Nios II debug TAP data register.
package jtag_scan_pkg;

  localparam int MAX_LEN_DEF = 38;
  localparam int TLR_SLOTS   = 6;

  typedef enum logic [1:0] {
    OP_IR  = 2'b00,
    OP_DR  = 2'b01,
    OP_RST = 2'b10,
    OP_RSV = 2'b11
  } jtag_op_e;

  typedef enum logic [3:0] {
    S_RESET_SEQ = 4'd0,
    S_IDLE      = 4'd1,
    S_SEL       = 4'd2,
    S_CAPTURE   = 4'd3,
    S_SHIFT     = 4'd4,
    S_EXIT1     = 4'd5,
    S_UPDATE    = 4'd6,
    S_RTI_END   = 4'd7,
    S_RESP      = 4'd8,
    S_TLR_SEQ   = 4'd9
  } jtag_state_e;

  // States in which TCK pulses; every other state holds TCK low.
  function automatic logic tck_enabled(input jtag_state_e s);
    return (s == S_RESET_SEQ) || (s == S_TLR_SEQ) || (s == S_SEL) ||
           (s == S_CAPTURE) || (s == S_SHIFT) || (s == S_EXIT1) || (s == S_UPDATE);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: each bit slot is CLK_DIV clocks low followed by CLK_DIV clocks
// high. The rise/fall strobes are high in the clock that makes tck toggle.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          tck_q;
  logic          wrap;

  assign wrap   = en_i && (div_q == DW'(CLK_DIV - 1));
  assign rise_o = wrap && !tck_q;
  assign fall_o = wrap && tck_q;
  assign tck_o  = tck_q;

  // Disabling restarts the slot, so the next enable begins a fresh low phase.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else if (!en_i) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else if (wrap) begin
      div_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG initiator: sequences TMS/TDI for IR scans, DR scans and TAP
// resets, captures TDO during Shift-xR and returns it over a valid/ready port.
module jtag_scan_master
  import jtag_scan_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic [3:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid is never withdrawn by this block before ready, and payloads are
  // held stable while valid is high and ready is low.

  localparam int CW = ($clog2(MAX_LEN + 1) > 3) ? $clog2(MAX_LEN + 1) : 3;

  jtag_state_e        state_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      last_q;
  logic               is_ir_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] cap_q;
  logic [MAX_LEN-1:0] rsp_data_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic               busy_q;
  logic               tms_q;
  logic               tdi_q;

  logic               tck_en;
  logic               tck_rise;
  logic               tck_fall;
  logic [CW-1:0]      len_eff;

  function automatic logic pick(input logic [MAX_LEN-1:0] v, input logic [CW-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == CW'(i)) b = v[i];
    end
    return b;
  endfunction

  assign tck_en = tck_enabled(state_q);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (tck_en),
    .tck_o   (tck),
    .rise_o  (tck_rise),
    .fall_o  (tck_fall)
  );

  // Length 0 means one bit; anything beyond MAX_LEN is clamped, so the shift
  // counter never wraps.
  always_comb begin
    len_eff = CW'(cmd_len);
    if (cmd_len == 6'd0) begin
      len_eff = CW'(1);
    end else if (int'(cmd_len) > MAX_LEN) begin
      len_eff = CW'(MAX_LEN);
    end
  end

  // Every sequence begins with TMS=1, so each final slot leaves tms at 1; TMS
  // and TDI then only ever move on a TCK falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RESET_SEQ;
      cnt_q       <= '0;
      last_q      <= '0;
      is_ir_q     <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (state_q == S_SHIFT && tck_rise && cnt_q == CW'(i)) cap_q[i] <= tdo;
      end

      case (state_q)
        S_RESET_SEQ, S_TLR_SEQ: begin
          if (tck_fall) begin
            if (cnt_q == CW'(TLR_SLOTS - 1)) begin
              cnt_q  <= '0;
              tms_q  <= 1'b1;
              busy_q <= 1'b0;
              if (state_q == S_RESET_SEQ) begin
                state_q     <= S_IDLE;
                cmd_ready_q <= 1'b1;
              end else begin
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
              tms_q <= (cnt_q != CW'(TLR_SLOTS - 2));
            end
          end
        end

        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            data_q      <= cmd_data;
            cap_q       <= '0;
            last_q      <= len_eff - CW'(1);
            cnt_q       <= '0;
            tms_q       <= 1'b1;
            is_ir_q     <= (cmd_op == OP_IR);
            if (cmd_op == OP_IR || cmd_op == OP_DR) state_q <= S_SEL;
            else                                    state_q <= S_TLR_SEQ;
          end
        end

        S_SEL: begin
          if (tck_fall) begin
            if (is_ir_q && cnt_q == '0) begin
              cnt_q <= CW'(1);
              tms_q <= 1'b1;
            end else begin
              state_q <= S_CAPTURE;
              cnt_q   <= '0;
              tms_q   <= 1'b0;
            end
          end
        end

        // Two TMS=0 slots: Select -> Capture, then Capture -> Shift.
        S_CAPTURE: begin
          if (tck_fall) begin
            if (cnt_q == '0) begin
              cnt_q <= CW'(1);
              tms_q <= 1'b0;
            end else begin
              state_q <= S_SHIFT;
              cnt_q   <= '0;
              tms_q   <= (last_q == '0);
              tdi_q   <= pick(data_q, '0);
            end
          end
        end

        S_SHIFT: begin
          if (tck_fall) begin
            if (cnt_q == last_q) begin
              state_q <= S_EXIT1;
              cnt_q   <= '0;
              tms_q   <= 1'b1;
              tdi_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              tms_q <= ((cnt_q + CW'(1)) == last_q);
              tdi_q <= pick(data_q, cnt_q + CW'(1));
            end
          end
        end

        S_EXIT1: begin
          if (tck_fall) begin
            state_q <= S_UPDATE;
            tms_q   <= 1'b0;
          end
        end

        S_UPDATE: begin
          if (tck_fall) begin
            state_q <= S_RTI_END;
            tms_q   <= 1'b1;
          end
        end

        S_RTI_END: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= cap_q;
          busy_q      <= 1'b0;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_RESET_SEQ;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          tms_q   <= 1'b1;
          tdi_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign tms         = tms_q;
  assign tdi         = tdi_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural IEEE 1149.1 TAP (2-bit IR, 1-bit
// loopback DR) answers the DUT; responses are predicted from the scan rules.
module tb_jtag_scan_master;

  localparam int MAX_LEN = 38;
  localparam int D       = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [5:0]         cmd_len = 6'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo = 1'b0;
  logic [3:0]         dbg_state;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .tck         (tck),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .dbg_state_o (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural TAP ----------------
  typedef enum int {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_e;

  tap_e       tap = T_TLR;
  logic       dr_bit = 1'b0;
  logic [1:0] ir_sh = 2'b00;
  logic [1:0] ir_q = 2'b11;
  bit         tms_obs[$];
  int         shift_edges = 0;
  int         tdi_idle_err = 0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDR  : T_PADR;
      T_PADR:  return m ? T_EX2DR : T_PADR;
      T_EX2DR: return m ? T_UPDR  : T_SHDR;
      T_UPDR:  return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPIR  : T_PAIR;
      T_PAIR:  return m ? T_EX2IR : T_PAIR;
      T_EX2IR: return m ? T_UPIR  : T_SHIR;
      default: return m ? T_SELDR : T_RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_obs.push_back(tms);
    if (tap == T_SHDR || tap == T_SHIR) shift_edges++;
    else if (tdi !== 1'b0) tdi_idle_err++;
    case (tap)
      T_CAPDR: dr_bit = 1'b0;
      T_SHDR:  dr_bit = tdi;
      T_CAPIR: ir_sh = 2'b01;
      T_SHIR:  ir_sh = {tdi, ir_sh[1]};
      default: ;
    endcase
    tap = tap_next(tap, tms);
    if (tap == T_UPIR) ir_q = ir_sh;
    if (tap == T_TLR)  ir_q = 2'b11;
  end

  always @(negedge tck) tdo = (tap == T_SHDR) ? dr_bit : (tap == T_SHIR) ? ir_sh[0] : 1'b0;

  // TMS/TDI may only move on the clk edge that drops TCK.
  int   edge_err = 0;
  int   rsp_hi = 0;
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0, p_reset = 1'b1;
  always @(negedge clk) begin
    if (!reset && !p_reset && (tms !== p_tms || tdi !== p_tdi) && !(p_tck === 1'b1 && tck === 1'b0))
      edge_err++;
    if (rsp_valid === 1'b1) rsp_hi++;
    p_tck = tck; p_tms = tms; p_tdi = tdi; p_reset = reset;
  end

  // ---------------- scoreboard ----------------
  logic [MAX_LEN-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_obs();
    logic [63:0] v;
    v = '0;
    foreach (tms_obs[i]) if (i < 64) v[i] = tms_obs[i];
    return v;
  endfunction

  function automatic void exp_tms(input int op, input int le, output logic [63:0] v, output int n);
    v = '0;
    n = 0;
    if (op >= 2) begin
      v = 64'b011111;
      n = 6;
    end else begin
      v[n] = 1'b1; n++;
      if (op == 0) begin v[n] = 1'b1; n++; end
      v[n] = 1'b0; n++;
      v[n] = 1'b0; n++;
      for (int k = 0; k < le; k++) begin v[n] = (k == le - 1); n++; end
      v[n] = 1'b1; n++;
      v[n] = 1'b0; n++;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    int rsp0;
    int i;
    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_outs", {58'd0, tck, tms, tdi, cmd_ready, rsp_valid, busy}, 64'b010001);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    tms_obs.delete();
    rsp0 = rsp_hi;
    for (i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk);
    chk("rst_tms_n", 64'(tms_obs.size()), 64'd6);
    chk("rst_tms_seq", pack_obs(), 64'b011111);
    chk("rst_ready_busy", {62'd0, cmd_ready, busy}, 64'b10);
    chk("rst_no_rsp", 64'(rsp_hi - rsp0), 64'd0);
    chk("rst_tap_rti", 64'(tap == T_RTI), 64'd1);
  endtask

  task automatic do_scan(input int op, input int len, input logic [MAX_LEN-1:0] data, input int hold);
    int le, exp_lat, lat, t0, n_e, i, stab;
    logic [63:0] m, d64, etms, er;
    logic [65:0] s;
    logic [1:0] exp_ir;
    logic [MAX_LEN-1:0] held;
    le  = (len == 0) ? 1 : (len > MAX_LEN ? MAX_LEN : len);
    m   = (64'd1 << le) - 64'd1;
    d64 = 64'(data);
    if (op == 1)      er = (d64 << 1) & m;
    else if (op == 0) er = ((d64 << 2) | 64'd1) & m;
    else              er = 64'd0;
    exp_q.push_back(er[MAX_LEN-1:0]);
    s = {d64, 2'b01};
    s = s >> le;
    exp_ir = s[1:0];
    exp_tms(op, le, etms, n_e);
    exp_lat = (op == 1) ? 2*D*(le + 5) : (op == 0) ? 2*D*(le + 6) : 2*D*6;

    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_len   = 6'(len);
    cmd_data  = data;
    for (i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    chk("accept_ready", 64'(cmd_ready), 64'd1);
    tms_obs.delete();
    shift_edges = 0;
    tdi_idle_err = 0;
    @(negedge clk);
    t0 = cyc;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_len   = 6'($urandom_range(0, 63));
    cmd_data  = MAX_LEN'({$urandom(), $urandom()});
    chk("busy_run", {62'd0, busy, cmd_ready}, 64'b10);

    while (rsp_valid !== 1'b1 && cyc - t0 < exp_lat + 10) @(negedge clk);
    lat = cyc - t0;
    chk($sformatf("latency lat=%0d exp=%0d", lat, exp_lat), 64'(lat >= exp_lat && lat <= exp_lat + 1), 64'd1);
    chk("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
    chk("tms_n", 64'(tms_obs.size()), 64'(n_e));
    chk("tms_seq", pack_obs(), etms);
    chk("shift_n", 64'(shift_edges), (op >= 2) ? 64'd0 : 64'(le));
    chk("tdi_idle", 64'(tdi_idle_err), 64'd0);
    chk("tap_rti", 64'(tap == T_RTI), 64'd1);
    if (op == 0)      chk("ir_update", 64'(ir_q), 64'(exp_ir));
    else if (op >= 2) chk("ir_tlr", 64'(ir_q), 64'b11);

    held = rsp_data;
    stab = 0;
    for (i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== held || tck !== 1'b0 || cmd_ready !== 1'b0) stab++;
    end
    chk("hold_stable", 64'(stab), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_rsp", {62'd0, rsp_valid, cmd_ready}, 64'b01);
  endtask

  task automatic mid_scan_reset();
    int i;
    for (i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_len   = 6'd38;
    cmd_data  = MAX_LEN'({$urandom(), $urandom()});
    shift_edges = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (i = 0; i < 400 && shift_edges < 10; i++) @(negedge clk);
    chk("mid_reached_bit10", 64'(shift_edges), 64'd10);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {60'd0, tck, tms, rsp_valid, cmd_ready}, 64'b0100);
    do_reset(3);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [63:0] r;
    do_reset(4);

    do_scan(1, 38, 38'h2A_5555_AAAA, 2);
    do_scan(0, 2, 38'h2, 0);
    do_scan(1, 7, 38'h5B, 20);
    do_scan(1, 0, 38'h3F_FFFF_FFFF, 1);
    do_scan(1, 50, 38'h15_A5A5_0F0F, 1);
    do_scan(2, 12, 38'h1234, 3);
    do_scan(3, 3, 38'h7, 0);
    do_scan(0, 1, 38'h1, 1);

    for (int k = 0; k < 16; k++) begin
      r = {$urandom(), $urandom()};
      do_scan($urandom_range(0, 3), $urandom_range(0, 63), r[MAX_LEN-1:0], $urandom_range(0, 5));
    end

    mid_scan_reset();
    do_scan(1, 38, 38'h00_FFFF_0000, 1);

    chk("tms_tdi_on_fall_only", 64'(edge_err), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
